// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output chain.
//   FIR_TAPS / FIR_LAT : FIR geometry; together they set how many samples
//                        are pipeline-fill transient after reset (SKIP_DEF).
//   IN_W_DEF/OUT_W_DEF : Q2.30 FIR sum in, Q1.15 sample out.
//   OUT_MAX / OUT_MIN  : Q1.15 saturation rails.
//   state_e            : output-stage warm-up FSM states.
package fir_pkg;
  localparam int FIR_TAPS  = 56;
  // input, product and sum registers ahead of the FIR output
  localparam int FIR_LAT   = 3;
  localparam int SKIP_DEF  = FIR_TAPS + FIR_LAT;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;

  localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = 16'sh8000;

  typedef enum logic {WARMUP, RUN} state_e;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst     : rising-edge clock, synchronous active-low reset
//   wr_en/wr_data: write request; accepted if not full or a read frees a slot
//   rd_en        : pop head when non-empty (ignored when empty)
//   rd_data      : head word, 0 when empty
//   level        : occupancy 0..DEPTH
//   valid        : non-empty
//   drop         : write request rejected this cycle (full, no read)
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     valid,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             empty, full, do_rd, do_wr;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == (AW+1)'(DEPTH));
    do_rd  = rd_en && !empty;
    // a read in the same cycle frees the slot, so a full FIFO still accepts
    do_wr  = wr_en && (!full || do_rd);
    drop   = wr_en && full && !do_rd;
    wptr_d = do_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d = do_rd ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rptr_q];
  assign valid   = !empty;
  assign level   = cnt_q;
endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: round/saturate Q2.30 -> Q1.15, discard the post-reset
// fill transient, decimate, and buffer in a FWFT FIFO (valid/ready).
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   in_en, in_data      : FIR sample strobe and signed sum
//   out_data/valid/ready: FIFO head handshake (out_data=0 when empty)
//   level               : FIFO occupancy
//   warm                : fill transient has been discarded
//   sat_flag, ovf_flag  : sticky saturation / FIFO-full drop flags
//   clr_flags           : clear both flags (a same-cycle set wins)
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = 15,
  parameter int SKIP       = SKIP_DEF,
  parameter int DECIM      = 4,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [IN_W-1:0]        in_data,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   warm,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  input  logic                   clr_flags
);
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam state_e RST_STATE = (SKIP == 0) ? RUN : WARMUP;
  localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (FRAC_SHIFT - 1);

  typedef struct packed {
    logic             keep;
    logic [OUT_W-1:0] word;
  } s1_t;

  state_e         state_q, state_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic [PW-1:0]  phase_q, phase_d;
  s1_t            s1_q, s1_d;
  logic           sat_q, sat_d, ovf_q, ovf_d;
  logic           sat_set, fifo_drop;

  // ---- round half up, arithmetic shift, saturate ----
  logic [IN_W:0]        t_rnd;
  logic signed [IN_W:0] r_shf;
  logic                 sat_hi, sat_lo;
  logic [OUT_W-1:0]     q_word;

  always_comb begin
    t_rnd  = {in_data[IN_W-1], in_data} + RND;
    r_shf  = $signed(t_rnd) >>> FRAC_SHIFT;
    // in range iff every bit above the Q1.15 sign bit equals the sign
    sat_hi = !r_shf[IN_W] &&  (|r_shf[IN_W-1:OUT_W-1]);
    sat_lo =  r_shf[IN_W] && !(&r_shf[IN_W-1:OUT_W-1]);
    if (sat_hi)      q_word = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) q_word = {1'b1, {(OUT_W-1){1'b0}}};
    else             q_word = r_shf[OUT_W-1:0];
  end

  // ---- warm-up / decimation FSM and stage 1 ----
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    phase_d = phase_q;
    s1_d    = '0;
    sat_set = 1'b0;
    case (state_q)
      WARMUP: begin
        if (in_en) begin
          skip_d = skip_q + SKW'(1);
          // the sample that completes the skip is itself discarded
          if (skip_d == SKW'(SKIP)) state_d = RUN;
        end
      end
      RUN: begin
        if (in_en) begin
          if (phase_q == '0) begin
            s1_d.keep = 1'b1;
            s1_d.word = q_word;
            sat_set   = sat_hi || sat_lo;
          end
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
      end
      default: state_d = RST_STATE;
    endcase
    sat_d = sat_set   || (sat_q && !clr_flags);
    ovf_d = fifo_drop || (ovf_q && !clr_flags);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_STATE;
      skip_q  <= '0;
      phase_q <= '0;
      s1_q    <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      phase_q <= phase_d;
      s1_q    <= s1_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---- stage 2: FIFO write ----
  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_q.keep),
    .wr_data (s1_q.word),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .level   (level),
    .valid   (out_valid),
    .drop    (fifo_drop)
  );

  assign warm     = (state_q == RUN);
  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;
endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;
  import fir_pkg::*;

  localparam int SKIP  = SKIP_DEF;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, en1, en4, rdy1, rdy4;
  logic [31:0] in_data;
  logic [15:0] od1, od4;
  logic [3:0]  lv1, lv4;
  logic        ov1, ov4, w1, w4, sat1, sat4, ovf1, ovf4;

  fir_out_requant #(.DECIM(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .in_en(en1), .in_data(in_data),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .level(lv1),
    .warm(w1), .sat_flag(sat1), .ovf_flag(ovf1), .clr_flags(clr));

  fir_out_requant #(.DECIM(4), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .in_en(en4), .in_data(in_data),
    .out_data(od4), .out_valid(ov4), .out_ready(rdy4), .level(lv4),
    .warm(w4), .sat_flag(sat4), .ovf_flag(ovf4), .clr_flags(clr));

  int checks = 0, errors = 0;
  int cnt1 = 0, cnt4 = 0;
  logic [15:0] q1[$], q4[$];

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    bit          sat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] quant(input logic [31:0] d);
    longint r;
    r = (longint'($signed(d)) + 64'sd16384) >>> 15;
    if (r > longint'(OUT_MAX)) r = longint'(OUT_MAX);
    if (r < longint'(OUT_MIN)) r = longint'(OUT_MIN);
    return r[15:0];
  endfunction

  // n = 0-based sample index since reset
  function automatic bit kept(input int n, input int decim);
    return (n >= SKIP) && (((n - SKIP) % decim) == 0);
  endfunction

  task automatic send(input logic [31:0] d, input bit e1, input bit e4,
                      input bit p1, input bit p4);
    in_data = d; en1 = e1; en4 = e4;
    if (e1) begin if (p1 && kept(cnt1, 1)) q1.push_back(quant(d)); cnt1++; end
    if (e4) begin if (p4 && kept(cnt4, 4)) q4.push_back(quant(d)); cnt4++; end
    @(posedge clk); #1;
    en1 = 1'b0; en4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " out_valid"}, ov1, 0);
    chk({tag, " level"},     lv1, 0);
    chk({tag, " warm"},      w1, 0);
    chk({tag, " sat_flag"},  sat1, 0);
    chk({tag, " ovf_flag"},  ovf1, 0);
    chk({tag, " out_data"},  od1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    q1.delete(); q4.delete();
    cnt1 = 0; cnt4 = 0;
  endtask

  // scoreboards: pop on every accepted beat
  always @(negedge clk) begin
    if (rst && ov1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected beat: got %0d expected none", od1);
      end else chk("dut1 out_data", od1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst && ov4 && rdy4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4 unexpected beat: got %0d expected none", od4);
      end else chk("dut4 out_data", od4, q4.pop_front());
    end
  end

  initial begin
    tbl[0] = '{32'h0000_4000, 16'h0001, 1'b0};
    tbl[1] = '{32'h0000_3FFF, 16'h0000, 1'b0};
    tbl[2] = '{32'hFFFF_C000, 16'h0000, 1'b0};
    tbl[3] = '{32'hFFFF_BFFF, 16'hFFFF, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
    tbl[5] = '{32'h8000_0000, 16'h8000, 1'b1};
    tbl[6] = '{32'h3FFF_C000, 16'h7FFF, 1'b1};  // rounds to exactly +1.0
    tbl[7] = '{32'h3FFF_BFFF, 16'h7FFF, 1'b0};  // largest in-range value

    rst = 1'b0; clr = 1'b0; en1 = 1'b0; en4 = 1'b0;
    rdy1 = 1'b1; rdy4 = 1'b1; in_data = '0;
    idle(2);
    check_reset_state("reset");
    rst = 1'b1;

    // ---- warm-up ----
    for (int i = 1; i <= 60; i++) begin
      send(32'h0000_8000, 1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("warm after %0d", i), w1, (i >= SKIP) ? 1 : 0);
      chk($sformatf("no valid after %0d", i), ov1, 0);
    end
    chk("dut4 warm", w4, 1);
    idle(1);
    chk("first out_valid", ov1, 1);
    chk("first out_data", od1, 1);
    idle(3);

    // ---- rounding / saturation table ----
    for (int i = 0; i < 8; i++) begin
      q1.push_back(tbl[i].dout);
      send(tbl[i].din, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk($sformatf("sat_flag vec %0d", i), sat1, tbl[i].sat);
      clr = 1'b1; idle(1); clr = 1'b0;
      chk($sformatf("sat_flag clr %0d", i), sat1, 0);
    end

    // clear coincident with a saturating sample: set wins
    clr = 1'b1;
    send(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    chk("sat set wins over clr", sat1, 1);
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("sat cleared", sat1, 0);
    idle(3);
    chk("dut1 queue drained", q1.size(), 0);

    // ---- decimation by 4 on a ramp ----
    do_reset();
    for (int i = 0; i < SKIP; i++) send(32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) send(32'(k) << 15, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("decim queue drained", q4.size(), 0);
    chk("decim level", lv4, 0);

    // ---- backpressure / overflow ----
    rdy1 = 1'b0;
    for (int i = 1; i <= 10; i++) send(32'(i) << 15, 1'b1, 1'b0, (i <= DEPTH), 1'b0);
    idle(2);
    chk("ovf level", lv1, DEPTH);
    chk("ovf flag", ovf1, 1);
    chk("ovf out_valid", ov1, 1);
    rdy1 = 1'b1;
    idle(DEPTH + 2);
    chk("ovf drained level", lv1, 0);
    chk("ovf queue drained", q1.size(), 0);

    // full with simultaneous read and write
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("ovf cleared", ovf1, 0);
    rdy1 = 1'b0;
    for (int i = 1; i <= DEPTH; i++) send(32'(i + 20) << 15, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("refill level", lv1, DEPTH);
    send(32'(30) << 15, 1'b1, 1'b0, 1'b1, 1'b0);
    rdy1 = 1'b1; idle(1); rdy1 = 1'b0;
    chk("rd+wr full level", lv1, DEPTH);
    chk("rd+wr full no ovf", ovf1, 0);
    rdy1 = 1'b1;
    idle(DEPTH + 3);
    chk("rd+wr drained level", lv1, 0);
    chk("rd+wr queue drained", q1.size(), 0);

    // ---- reset mid-run ----
    rdy1 = 1'b0;
    for (int i = 0; i < 5; i++)
      send((i == 2) ? 32'h7FFF_FFFF : 32'(i) << 15, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("pre-reset level", lv1, 5);
    chk("pre-reset sat", sat1, 1);
    rst = 1'b0;
    idle(1);
    check_reset_state("mid reset");
    rst = 1'b1;
    q1.delete(); q4.delete();
    cnt1 = 0; cnt4 = 0;
    rdy1 = 1'b1;
    for (int i = 1; i <= SKIP; i++) begin
      send(32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i >= SKIP - 1) chk($sformatf("rewarm after %0d", i), w1, (i >= SKIP) ? 1 : 0);
      chk($sformatf("rewarm no valid %0d", i), ov1, 0);
    end
    send(32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rewarm latency t+1", ov1, 0);
    idle(1);
    chk("rewarm out_valid", ov1, 1);
    chk("rewarm out_data", od1, 2);
    idle(3);
    chk("final queue dut1", q1.size(), 0);
    chk("final queue dut4", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
